// File: rtl/sharpen_stream_ctrl.sv
// sharpen_stream_ctrl
// Frame-level flow controller in front of the 3x3 sharpen filter.
// It forwards pixels from an upstream valid/ready source to the filter's
// valid-only input. A new row is admitted only while a line-buffer credit is
// free, and the filter returns credits with f_line_done. The block also counts
// filter output pixels and pulses done when the frame has fully emerged.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             frame start pulse, honoured only in IDLE
//   s_pixel/s_valid   upstream pixel and valid
//   s_ready           pixel accepted this cycle (combinational)
//   f_pixel/f_valid   pixel and strobe to the filter (combinational)
//   f_line_done       filter freed one line buffer (credit return)
//   f_out_valid       filter produced one output pixel
//   busy              controller is not IDLE
//   done              one-cycle pulse at frame completion
//   credit_err        sticky: credit returned while credits were already full
module sharpen_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int NUM_LINES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] f_pixel,
  output logic                  f_valid,
  input  logic                  f_line_done,
  input  logic                  f_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  credit_err
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam int CRD_W = $clog2(NUM_LINES + 1);
  localparam int OUT_W = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

  localparam logic [COL_W-1:0] COL_ZERO   = {COL_W{1'b0}};
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO   = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_PRIMED = ROW_W'(2);
  localparam logic [CRD_W-1:0] CRD_ZERO   = {CRD_W{1'b0}};
  localparam logic [CRD_W-1:0] CRD_ONE    = CRD_W'(1);
  localparam logic [CRD_W-1:0] CRD_MAX    = CRD_W'(NUM_LINES);
  localparam logic [OUT_W-1:0] OUT_ZERO   = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] OUT_ONE    = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_TARGET = OUT_W'((IMG_HEIGHT - 2) * IMG_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              credit_err_q, credit_err_d;

  logic in_accept_s;
  logic accept_s;
  logic take_credit_s;
  logic row_end_s;
  logic frame_end_s;
  logic counting_s;

  // Handshake: a row may only start with a free credit; a started row never stalls.
  always_comb begin
    in_accept_s   = (state_q == ST_FILL) || (state_q == ST_RUN);
    s_ready       = in_accept_s && ((col_q != COL_ZERO) || (credits_q != CRD_ZERO));
    accept_s      = s_valid && s_ready;
    take_credit_s = accept_s && (col_q == COL_ZERO);
    row_end_s     = accept_s && (col_q == COL_LAST);
    frame_end_s   = row_end_s && (row_q == ROW_LAST);
    counting_s    = in_accept_s || (state_q == ST_DRAIN);
  end

  assign f_pixel    = s_pixel;
  assign f_valid    = accept_s;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign credit_err = credit_err_q;

  // Next-state computation for counters, credits and the frame FSM.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    credits_d    = credits_q;
    out_cnt_d    = out_cnt_q;
    credit_err_d = credit_err_q;

    // Credits persist across frames; a simultaneous take and return cancel out.
    if (take_credit_s && !f_line_done) begin
      credits_d = credits_q - CRD_ONE;
    end else if (!take_credit_s && f_line_done) begin
      if (credits_q == CRD_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRD_ONE;
      end
    end else begin
      credits_d = credits_q;
    end

    if ((state_q == ST_IDLE) && start) begin
      col_d     = COL_ZERO;
      row_d     = ROW_ZERO;
      out_cnt_d = OUT_ZERO;
    end else begin
      if (row_end_s) begin
        col_d = COL_ZERO;
        row_d = row_q + ROW_W'(1);
      end else if (accept_s) begin
        col_d = col_q + COL_W'(1);
      end else begin
        col_d = col_q;
      end
      // Saturate at the target so a malformed, over-long output burst cannot wrap.
      if (counting_s && f_out_valid && (out_cnt_q != OUT_TARGET)) begin
        out_cnt_d = out_cnt_q + OUT_ONE;
      end else begin
        out_cnt_d = out_cnt_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        // A 3-row frame finishes its input while still priming the window.
        if (frame_end_s) begin
          state_d = ST_DRAIN;
        end else if (row_end_s && (row_q == ROW_PRIMED)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN: begin
        if (frame_end_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Uses the updated count so done follows the final output pixel directly.
        if (out_cnt_d == OUT_TARGET) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= COL_ZERO;
      row_q        <= ROW_ZERO;
      credits_q    <= CRD_MAX;
      out_cnt_q    <= OUT_ZERO;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      credits_q    <= credits_d;
      out_cnt_q    <= out_cnt_d;
      credit_err_q <= credit_err_d;
    end
  end

endmodule

// File: tb/tb_sharpen_stream_ctrl.sv
// Self-checking bench for sharpen_stream_ctrl with a 4x5 frame and 4 credits.
module tb_sharpen_stream_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] s_pixel;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] f_pixel;
  logic       f_valid;
  logic       f_line_done;
  logic       f_out_valid;
  logic       busy;
  logic       done;
  logic       credit_err;

  int checks;
  int errors;
  int cnt;

  sharpen_stream_ctrl #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(5),
    .NUM_LINES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_pixel    (s_pixel),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .f_pixel    (f_pixel),
    .f_valid    (f_valid),
    .f_line_done(f_line_done),
    .f_out_valid(f_out_valid),
    .busy       (busy),
    .done       (done),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic rst;
    logic start;
    logic s_valid;
    logic line_done;
    logic out_valid;
    logic exp_ready;
    logic exp_fvalid;
    logic exp_busy;
    logic exp_done;
    logic exp_cerr;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    s_pixel     = 8'h00;
    s_valid     = 1'b0;
    f_line_done = 1'b0;
    f_out_valid = 1'b0;

    //            rst   start s_vld ldone ovld  ready fvld  busy  done  cerr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    step();
    step();

    // Table: reset state, start, accept/stall, start-while-busy, reset, credit overflow.
    for (int i = 0; i <= 10; i++) begin
      rst         = vecs[i].rst;
      start       = vecs[i].start;
      s_valid     = vecs[i].s_valid;
      f_line_done = vecs[i].line_done;
      f_out_valid = vecs[i].out_valid;
      s_pixel     = 8'(8'h30 + i);
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_f_valid", i), 32'(f_valid), 32'(vecs[i].exp_fvalid));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d_credit_err", i), 32'(credit_err), 32'(vecs[i].exp_cerr));
      chk($sformatf("vec%0d_f_pixel", i), 32'(f_pixel), 32'(8'h30 + i));
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    f_line_done = 1'b0;
    f_out_valid = 1'b0;
    chk("post_table_credits", 32'(dut.credits_q), 32'd4);

    // Full frame with no credit returns: only four rows fit.
    start = 1'b1;
    step();
    start = 1'b0;
    s_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (f_valid) cnt++;
      step();
    end
    #1;
    chk("fill_pixel_count", 32'(cnt), 32'd16);
    chk("fill_stall_s_ready", 32'(s_ready), 32'd0);
    chk("fill_stall_row", 32'(dut.row_q), 32'd4);
    chk("fill_stall_col", 32'(dut.col_q), 32'd0);
    chk("fill_stall_credits", 32'(dut.credits_q), 32'd0);
    chk("fill_stall_busy", 32'(busy), 32'd1);

    // One credit returned: the last row goes through and input stops.
    f_line_done = 1'b1;
    step();
    f_line_done = 1'b0;
    #1;
    chk("credit_return_s_ready", 32'(s_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (f_valid) cnt++;
      step();
    end
    s_valid = 1'b0;
    #1;
    chk("last_row_count", 32'(cnt), 32'd4);
    chk("drain_s_ready", 32'(s_ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_credits", 32'(dut.credits_q), 32'd0);

    // Eleven output pixels are not enough to finish the frame.
    for (int i = 0; i < 11; i++) begin
      f_out_valid = 1'b1;
      step();
    end
    f_out_valid = 1'b0;
    step();
    step();
    step();
    chk("drain11_busy", 32'(busy), 32'd1);
    chk("drain11_done", 32'(done), 32'd0);
    f_out_valid = 1'b1;
    step();
    f_out_valid = 1'b0;
    chk("drain12_done", 32'(done), 32'd1);
    chk("drain12_busy", 32'(busy), 32'd1);
    step();
    chk("after_done_done", 32'(done), 32'd0);
    chk("after_done_busy", 32'(busy), 32'd0);

    // Return one credit in IDLE, then take and return in the same cycle.
    f_line_done = 1'b1;
    step();
    f_line_done = 1'b0;
    chk("idle_return_credits", 32'(dut.credits_q), 32'd1);
    chk("idle_return_cerr", 32'(credit_err), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    s_valid = 1'b1;
    f_line_done = 1'b1;
    #1;
    chk("same_cycle_f_valid", 32'(f_valid), 32'd1);
    step();
    s_valid = 1'b0;
    f_line_done = 1'b0;
    chk("same_cycle_credits", 32'(dut.credits_q), 32'd1);
    chk("same_cycle_cerr", 32'(credit_err), 32'd0);
    chk("same_cycle_col", 32'(dut.col_q), 32'd1);

    // start while busy must not disturb the counters.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_col", 32'(dut.col_q), 32'd1);
    chk("busy_start_row", 32'(dut.row_q), 32'd0);
    chk("busy_start_busy", 32'(busy), 32'd1);
    chk("busy_start_credits", 32'(dut.credits_q), 32'd1);

    // Move to col 2 of row 1, then reset mid-row.
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("midrow_accept%0d", i), 32'(f_valid), 32'd1);
      step();
    end
    s_valid = 1'b0;
    chk("midrow_col", 32'(dut.col_q), 32'd2);
    chk("midrow_row", 32'(dut.row_q), 32'd1);
    chk("midrow_credits", 32'(dut.credits_q), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrow_rst_s_ready", 32'(s_ready), 32'd0);
    chk("midrow_rst_busy", 32'(busy), 32'd0);
    chk("midrow_rst_credits", 32'(dut.credits_q), 32'd4);
    chk("midrow_rst_col", 32'(dut.col_q), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
